doorlock_ctrl: RTL and testbench

DOORLOCK_CTRL -- requirements
Module: doorlock_ctrl

---
 rtl/doorlock_pkg.sv | 48 ++++
 rtl/doorlock_timer.sv | 41 ++++
 rtl/doorlock_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_doorlock_ctrl.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/doorlock_pkg.sv
// ============================================================================
// doorlock_pkg : shared state encoding, key-mode codes and key decoder
// Rev 1.0
// ============================================================================
`default_nettype none

package doorlock_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    CHECK   = 3'd2,
    OPEN    = 3'd3,
    LOCKOUT = 3'd4
  } state_e;

  localparam logic [1:0] MODE_DIGIT   = 2'd0;
  localparam logic [1:0] MODE_ENTER   = 2'd1;
  localparam logic [1:0] MODE_CLEAR   = 2'd2;
  localparam logic [1:0] MODE_INVALID = 2'd3;

  typedef enum logic [1:0] {
    KEY_NONE  = 2'd0,
    KEY_DIGIT = 2'd1,
    KEY_ENTER = 2'd2,
    KEY_CLEAR = 2'd3
  } key_e;

  // Non-BCD digit values fold into KEY_NONE alongside the explicit invalid mode.
  function automatic key_e decode_key(input logic       vld,
                                      input logic [1:0] mode,
                                      input logic [3:0] num);
    key_e k;
    k = KEY_NONE;
    if (vld) begin
      case (mode)
        MODE_DIGIT: k = (num <= 4'd9) ? KEY_DIGIT : KEY_NONE;
        MODE_ENTER: k = KEY_ENTER;
        MODE_CLEAR: k = KEY_CLEAR;
        default:    k = KEY_NONE;
      endcase
    end
    return k;
  endfunction

endpackage

`default_nettype wire

// File: rtl/doorlock_timer.sv
// ============================================================================
// doorlock_timer : loadable down-counter, saturates at zero, done when zero
// Rev 1.0
// ============================================================================
`default_nettype none

module doorlock_timer #(
  parameter int WIDTH = 13
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             done_o
);

  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/doorlock_ctrl.sv
// ============================================================================
// doorlock_ctrl : keypad door-lock controller (entry, check, open, lockout)
// Define DOORLOCK_PW_CHANGE_EN to allow a new password to be keyed in OPEN.
// Rev 1.0
// ============================================================================
`default_nettype none

module doorlock_ctrl
  import doorlock_pkg::*;
#(
  parameter int                  PW_LEN      = 4,
  parameter logic [4*PW_LEN-1:0] DEF_PW      = 16'h1234,
  parameter int                  MAX_FAIL    = 3,
  parameter int                  UNLOCK_CYC  = 1000,
  parameter int                  LOCKOUT_CYC = 5000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       key_vld_i,
  input  logic [1:0] mode_i,
  input  logic [3:0] num_i,
  output logic       unlock_o,
  output logic       err_o,
  output logic       alarm_o,
  output logic [3:0] digit_cnt_o
);

  localparam int PW_W    = 4 * PW_LEN;
  localparam int TMR_MAX = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int FAIL_W  = (MAX_FAIL > 1) ? $clog2(MAX_FAIL + 1) : 1;

  localparam logic [3:0]        FULL_CNT     = 4'(PW_LEN);
  localparam logic [FAIL_W-1:0] LAST_FAIL    = FAIL_W'(MAX_FAIL - 1);
  localparam logic [TMR_W-1:0]  UNLOCK_LOAD  = TMR_W'(UNLOCK_CYC - 1);
  localparam logic [TMR_W-1:0]  LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYC - 1);

  state_e            state_d, state_q;
  logic [PW_W-1:0]   buf_d, buf_q;
  logic [3:0]        cnt_d, cnt_q;
  logic              ovf_d, ovf_q;
  logic [FAIL_W-1:0] fail_d, fail_q;
  logic              err_d, err_q;
  logic [PW_W-1:0]   stored_pw;

  key_e              key;
  logic              take_digit;
  logic              clr_entry;
  logic              entry_full;
  logic              pw_match;
  logic              last_fail;
  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_val;
  logic              tmr_done;

`ifdef DOORLOCK_PW_CHANGE_EN
  logic [PW_W-1:0]   pw_d, pw_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pw_q <= DEF_PW;
    end else begin
      pw_q <= pw_d;
    end
  end

  assign stored_pw = pw_q;
`else
  assign stored_pw = DEF_PW;
`endif

  assign key        = decode_key(key_vld_i, mode_i, num_i);
  assign entry_full = (cnt_q == FULL_CNT) && !ovf_q;
  assign pw_match   = entry_full && (buf_q == stored_pw);
  assign last_fail  = (fail_q >= LAST_FAIL);

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    fail_d     = fail_q;
    err_d      = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    take_digit = 1'b0;
    clr_entry  = 1'b0;
`ifdef DOORLOCK_PW_CHANGE_EN
    pw_d       = pw_q;
`endif

    case (state_q)
      IDLE, ENTRY: begin
        case (key)
          KEY_DIGIT: begin
            take_digit = 1'b1;
            state_d    = ENTRY;
          end
          KEY_ENTER: state_d = CHECK;
          KEY_CLEAR: begin
            clr_entry = 1'b1;
            state_d   = IDLE;
          end
          default: ;
        endcase
      end

      // The entry buffer is consumed by the comparison whatever the outcome.
      CHECK: begin
        clr_entry = 1'b1;
        if (pw_match) begin
          state_d  = OPEN;
          fail_d   = '0;
          tmr_load = 1'b1;
          tmr_val  = UNLOCK_LOAD;
        end else begin
          err_d = 1'b1;
          if (last_fail) begin
            state_d  = LOCKOUT;
            tmr_load = 1'b1;
            tmr_val  = LOCKOUT_LOAD;
          end else begin
            state_d = IDLE;
            fail_d  = fail_q + 1'b1;
          end
        end
      end

      OPEN: begin
        if (tmr_done) begin
          state_d   = IDLE;
          clr_entry = 1'b1;
        end
`ifdef DOORLOCK_PW_CHANGE_EN
        else begin
          case (key)
            KEY_DIGIT: take_digit = 1'b1;
            KEY_ENTER: begin
              clr_entry = 1'b1;
              if (entry_full) begin
                pw_d    = buf_q;
                state_d = IDLE;
              end else begin
                err_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
`endif
      end

      LOCKOUT: begin
        if (tmr_done) begin
          state_d = IDLE;
          fail_d  = '0;
        end
      end

      default: state_d = IDLE;
    endcase

    // A full buffer refuses further digits and remembers the attempt as overflow.
    if (clr_entry) begin
      buf_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (take_digit) begin
      if (cnt_q == FULL_CNT) begin
        ovf_d = 1'b1;
      end else begin
        buf_d = {buf_q[PW_W-5:0], num_i};
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      fail_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
    end
  end

  doorlock_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  assign unlock_o    = (state_q == OPEN);
  assign alarm_o     = (state_q == LOCKOUT);
  assign err_o       = err_q;
  assign digit_cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_doorlock_ctrl.sv
// ============================================================================
// tb_doorlock_ctrl : self-checking bench for doorlock_ctrl against a key-level model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_doorlock_ctrl;

  localparam int          PW_LEN      = 4;
  localparam logic [15:0] DEF_PW      = 16'h1234;
  localparam int          MAX_FAIL    = 3;
  localparam int          UNLOCK_CYC  = 1000;
  localparam int          LOCKOUT_CYC = 5000;

  logic       clk_i     = 1'b0;
  logic       rst_i     = 1'b0;
  logic       key_vld_i = 1'b0;
  logic [1:0] mode_i    = 2'd0;
  logic [3:0] num_i     = 4'd0;
  logic       unlock_o;
  logic       err_o;
  logic       alarm_o;
  logic [3:0] digit_cnt_o;

  doorlock_ctrl #(
    .PW_LEN      (PW_LEN),
    .DEF_PW      (DEF_PW),
    .MAX_FAIL    (MAX_FAIL),
    .UNLOCK_CYC  (UNLOCK_CYC),
    .LOCKOUT_CYC (LOCKOUT_CYC)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .key_vld_i   (key_vld_i),
    .mode_i      (mode_i),
    .num_i       (num_i),
    .unlock_o    (unlock_o),
    .err_o       (err_o),
    .alarm_o     (alarm_o),
    .digit_cnt_o (digit_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;
  bit inj;

  // Reference model: the digits typed so far, overflow, failure count and password.
  int m_digits[$];
  int m_pw[$];
  bit m_ovf;
  int m_fail;

  function automatic bit model_match();
    if (m_digits.size() != PW_LEN || m_ovf) return 1'b0;
    for (int i = 0; i < PW_LEN; i++)
      if (m_digits[i] != m_pw[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    logic [15:0] pw;
    pw = DEF_PW;
    m_digits.delete();
    m_pw.delete();
    m_ovf  = 1'b0;
    m_fail = 0;
    for (int i = 0; i < PW_LEN; i++) m_pw.push_back(int'(pw[15-4*i -: 4]));
  endtask

  task automatic model_key(input int mode, input int num);
    if (mode == 0 && num <= 9) begin
      if (m_digits.size() == PW_LEN) m_ovf = 1'b1;
      else m_digits.push_back(num);
    end else if (mode == 2) begin
      m_digits.delete();
      m_ovf = 1'b0;
    end
  endtask

  // One key strobe; starts and ends on a falling edge.
  task automatic strobe(input logic [1:0] mode, input logic [3:0] num);
    key_vld_i = 1'b1;
    mode_i    = mode;
    num_i     = num;
    @(posedge clk_i);
    @(negedge clk_i);
    key_vld_i = 1'b0;
    mode_i    = 2'($urandom_range(0, 3));
    num_i     = 4'($urandom_range(0, 15));
  endtask

  task automatic do_reset();
    rst_i     = 1'b0;
    key_vld_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    model_reset();
  endtask

  task automatic press_key(input int mode, input int num, input bit gap);
    strobe(2'(mode), 4'(num));
    model_key(mode, num);
    n_cmp++;
    if (digit_cnt_o !== 4'(m_digits.size()) || unlock_o !== 1'b0 || err_o !== 1'b0 || alarm_o !== 1'b0) begin
      n_bad++;
      $display("FAIL key(mode=%0d,num=%0d): digit_cnt=%0d unlock=%b err=%b alarm=%b, required digit_cnt=%0d unlock=0 err=0 alarm=0",
               mode, num, digit_cnt_o, unlock_o, err_o, alarm_o, m_digits.size());
    end
    if (gap) repeat ($urandom_range(0, 2)) @(negedge clk_i);
  endtask

  task automatic press_code(input logic [31:0] code, input int n, input bit gap);
    for (int i = 0; i < n; i++) press_key(0, int'(code[4*(n-1-i) +: 4]), gap);
  endtask

  // Length of a high phase of unlock_o (which=0) or alarm_o (which=1), optionally spraying keys.
  task automatic measure(input int which, input bit inject, output int len);
    logic sig, other;
    len = 0;
    for (int k = 0; k < ((which == 0) ? UNLOCK_CYC : LOCKOUT_CYC) + 20; k++) begin
      sig   = (which == 0) ? unlock_o : alarm_o;
      other = (which == 0) ? alarm_o : unlock_o;
      if (sig !== 1'b1) break;
      len++;
      if (k > 0) begin
        n_cmp++;
        if (err_o !== 1'b0 || other !== 1'b0 || digit_cnt_o !== 4'd0) begin
          n_bad++;
          $display("FAIL hold%0d cyc%0d: err=%b other=%b digit_cnt=%0d, required all 0",
                   which, k, err_o, other, digit_cnt_o);
        end
      end
      if (inject) begin
        key_vld_i = 1'($urandom_range(0, 1));
        mode_i    = 2'($urandom_range(0, 3));
        num_i     = 4'($urandom_range(0, 15));
      end
      @(negedge clk_i);
    end
    key_vld_i = 1'b0;
  endtask

  task automatic press_enter();
    bit match;
    int len;
    match = model_match();
    strobe(2'd1, 4'd0);
    n_cmp++;
    if (unlock_o !== 1'b0 || err_o !== 1'b0 || alarm_o !== 1'b0) begin
      n_bad++;
      $display("FAIL check_cycle: unlock=%b err=%b alarm=%b, required 0 0 0", unlock_o, err_o, alarm_o);
    end
    @(negedge clk_i);
    m_digits.delete();
    m_ovf = 1'b0;
    if (match) begin
      n_cmp++;
      if (unlock_o !== 1'b1 || err_o !== 1'b0 || alarm_o !== 1'b0) begin
        n_bad++;
        $display("FAIL unlock_start: unlock=%b err=%b alarm=%b, required 1 0 0", unlock_o, err_o, alarm_o);
      end
      measure(0, inj, len);
      n_cmp++;
      if (len != UNLOCK_CYC) begin
        n_bad++;
        $display("FAIL unlock_len: got %0d cycles, required %0d", len, UNLOCK_CYC);
      end
      m_fail = 0;
    end else begin
      n_cmp++;
      if (err_o !== 1'b1 || unlock_o !== 1'b0) begin
        n_bad++;
        $display("FAIL err_pulse: err=%b unlock=%b, required err=1 unlock=0", err_o, unlock_o);
      end
      if (m_fail + 1 >= MAX_FAIL) begin
        n_cmp++;
        if (alarm_o !== 1'b1) begin
          n_bad++;
          $display("FAIL alarm_start: alarm=%b, required 1", alarm_o);
        end
        measure(1, 1'b1, len);
        n_cmp++;
        if (len != LOCKOUT_CYC) begin
          n_bad++;
          $display("FAIL lockout_len: got %0d cycles, required %0d", len, LOCKOUT_CYC);
        end
        m_fail = 0;
      end else begin
        m_fail++;
        n_cmp++;
        if (alarm_o !== 1'b0) begin
          n_bad++;
          $display("FAIL no_alarm: alarm=%b at fail count %0d, required 0", alarm_o, m_fail);
        end
        @(negedge clk_i);
        n_cmp++;
        if (err_o !== 1'b0) begin
          n_bad++;
          $display("FAIL err_width: err=%b one cycle after pulse, required 0", err_o);
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (unlock_o !== 1'b0 || err_o !== 1'b0 || alarm_o !== 1'b0 || digit_cnt_o !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_state: unlock=%b err=%b alarm=%b digit_cnt=%0d, required all 0",
               unlock_o, err_o, alarm_o, digit_cnt_o);
    end
  endtask

  task automatic test_unlock();
    press_code(32'h1234, 4, 1'b1);
    press_enter();
  endtask

  task automatic test_lockout();
    repeat (MAX_FAIL) begin
      press_code(32'h1235, 4, 1'b1);
      press_enter();
    end
    press_code(32'h1234, 4, 1'b1);
    press_enter();
  endtask

  task automatic test_overflow();
    press_code(32'h12345, 5, 1'b1);
    press_enter();
    press_code(32'h12, 2, 1'b1);
    press_enter();
  endtask

  task automatic test_clear_invalid();
    press_key(0, 9, 1'b1);
    press_key(2, 0, 1'b1);
    press_key(0, 1, 1'b1);
    press_key(0, 2, 1'b1);
    press_key(3, 5, 1'b1);
    press_key(0, 12, 1'b1);
    press_key(0, 3, 1'b1);
    press_key(0, 4, 1'b1);
    press_enter();
  endtask

  task automatic test_reset_mid();
    press_code(32'h1234, 4, 1'b0);
    strobe(2'd1, 4'd0);
    @(negedge clk_i);
    n_cmp++;
    if (unlock_o !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_open: unlock=%b, required 1", unlock_o);
    end
    repeat ($urandom_range(1, 50)) @(negedge clk_i);
    do_reset();
    n_cmp++;
    if (unlock_o !== 1'b0 || err_o !== 1'b0 || alarm_o !== 1'b0 || digit_cnt_o !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_in_open: unlock=%b err=%b alarm=%b digit_cnt=%0d, required all 0",
               unlock_o, err_o, alarm_o, digit_cnt_o);
    end
    while (m_fail < MAX_FAIL - 1) begin
      press_code(32'h9999, 4, 1'b0);
      press_enter();
    end
    press_code(32'h9999, 4, 1'b0);
    strobe(2'd1, 4'd0);
    @(negedge clk_i);
    n_cmp++;
    if (alarm_o !== 1'b1 || err_o !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_lockout: alarm=%b err=%b, required 1 1", alarm_o, err_o);
    end
    repeat ($urandom_range(1, 100)) @(negedge clk_i);
    do_reset();
    n_cmp++;
    if (unlock_o !== 1'b0 || err_o !== 1'b0 || alarm_o !== 1'b0 || digit_cnt_o !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_in_lockout: unlock=%b err=%b alarm=%b digit_cnt=%0d, required all 0",
               unlock_o, err_o, alarm_o, digit_cnt_o);
    end
    // A cleared fail counter means this wrong attempt must not trip the alarm.
    press_code(32'h9999, 4, 1'b0);
    press_enter();
  endtask

  task automatic test_random();
    for (int a = 0; a < 10; a++) begin
      int kind;
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        for (int i = 0; i < PW_LEN; i++) begin
          if ($urandom_range(0, 3) == 0) press_key(3, $urandom_range(0, 15), 1'b1);
          if ($urandom_range(0, 3) == 0) press_key(0, $urandom_range(10, 15), 1'b1);
          press_key(0, m_pw[i], 1'b1);
        end
      end else if (kind == 1) begin
        int n;
        n = $urandom_range(0, PW_LEN + 2);
        for (int i = 0; i < n; i++) press_key(0, $urandom_range(0, 9), 1'b1);
      end else begin
        int n;
        n = $urandom_range(0, 8);
        for (int i = 0; i < n; i++) begin
          int md;
          md = $urandom_range(0, 3);
          if (md == 1) md = 2;
          press_key(md, $urandom_range(0, 15), 1'b1);
        end
      end
      press_enter();
    end
  endtask

  task automatic test_back_to_back();
    press_code(32'h1234, 4, 1'b0);
    press_enter();
    press_code(32'h5, 1, 1'b0);
    press_enter();
  endtask

`ifdef DOORLOCK_PW_CHANGE_EN
  task automatic test_pw_change();
    press_code(32'h1234, 4, 1'b0);
    strobe(2'd1, 4'd0);
    @(negedge clk_i);
    n_cmp++;
    if (unlock_o !== 1'b1) begin
      n_bad++;
      $display("FAIL pwc_open: unlock=%b, required 1", unlock_o);
    end
    strobe(2'd0, 4'd9);
    strobe(2'd0, 4'd9);
    n_cmp++;
    if (digit_cnt_o !== 4'd2) begin
      n_bad++;
      $display("FAIL pwc_fill: digit_cnt=%0d, required 2", digit_cnt_o);
    end
    strobe(2'd1, 4'd0);
    n_cmp++;
    if (err_o !== 1'b1 || unlock_o !== 1'b1 || digit_cnt_o !== 4'd0) begin
      n_bad++;
      $display("FAIL pwc_short: err=%b unlock=%b digit_cnt=%0d, required 1 1 0", err_o, unlock_o, digit_cnt_o);
    end
    for (int d = 5; d <= 8; d++) begin
      strobe(2'd0, 4'(d));
      n_cmp++;
      if (digit_cnt_o !== 4'(d - 4)) begin
        n_bad++;
        $display("FAIL pwc_digit%0d: digit_cnt=%0d, required %0d", d, digit_cnt_o, d - 4);
      end
    end
    strobe(2'd1, 4'd0);
    n_cmp++;
    if (unlock_o !== 1'b0 || err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL pwc_store: unlock=%b err=%b, required 0 0", unlock_o, err_o);
    end
    m_pw.delete();
    for (int d = 5; d <= 8; d++) m_pw.push_back(d);
    m_digits.delete();
    m_ovf  = 1'b0;
    m_fail = 0;
    press_code(32'h1234, 4, 1'b1);
    press_enter();
    press_code(32'h5678, 4, 1'b1);
    press_enter();
    do_reset();
  endtask
`endif

  initial begin
`ifdef DOORLOCK_PW_CHANGE_EN
    inj = 1'b0;
`else
    inj = 1'b1;
`endif
    @(negedge clk_i);
    test_reset();
    test_unlock();
    test_lockout();
    test_overflow();
    test_clear_invalid();
    test_reset_mid();
    test_random();
    test_back_to_back();
`ifdef DOORLOCK_PW_CHANGE_EN
    test_pw_change();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
